// File: rtl/elc_code_sender.sv
// Initiator for an electronic-lock keypad/card interface: sends a latched code one digit per
// enter strobe, inserts the card on request, and retries on error or response timeout.
module elc_code_sender #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned GAP       = 2,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [3*DIGITS-1:0]   code_i,
    input  logic                  card_avail_i,
    input  logic                  unlock_i,
    input  logic                  error_i,
    input  logic                  card_is_needed_i,
    output logic [2:0]            in_o,
    output logic                  enter_o,
    output logic                  card_is_in_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [2:0]            retries_o
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle, StSend, StGap, StWait, StCard, StDone, StFail
    } state_e;

    state_e                state_q;
    logic [3*DIGITS-1:0]   code_q;
    logic [IW-1:0]         idx_q;
    logic [GW-1:0]         gap_q;
    logic [TW-1:0]         timer_q;
    logic                  card_done_q;
    logic [2:0]            in_q;
    logic                  enter_q;
    logic                  card_is_in_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  fail_q;
    logic [2:0]            retries_q;

    // Digit k sits in the k-th 3-bit field counting from the MS end.
    function automatic logic [2:0] digit_of(input logic [3*DIGITS-1:0] c,
                                            input logic [IW-1:0] k);
        digit_of = 3'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (k == IW'(i)) digit_of = c[3*(int'(DIGITS)-1-i) +: 3];
        end
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            code_q       <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            timer_q      <= '0;
            card_done_q  <= 1'b0;
            in_q         <= 3'd0;
            enter_q      <= 1'b0;
            card_is_in_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            retries_q    <= 3'd0;
        end else begin
            // Strobe-type outputs default low so they are single-cycle by construction.
            in_q         <= 3'd0;
            enter_q      <= 1'b0;
            card_is_in_q <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        code_q      <= code_i;
                        retries_q   <= 3'd0;
                        idx_q       <= '0;
                        card_done_q <= 1'b0;
                        busy_q      <= 1'b1;
                        enter_q     <= 1'b1;
                        in_q        <= code_i[3*DIGITS-1 -: 3];
                        state_q     <= StSend;
                    end
                end
                StSend: begin
                    if (idx_q == IW'(DIGITS - 1)) begin
                        timer_q <= '0;
                        state_q <= StWait;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        gap_q   <= '0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (gap_q == GW'(GAP - 1)) begin
                        enter_q <= 1'b1;
                        in_q    <= digit_of(code_q, idx_q);
                        state_q <= StSend;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                StWait: begin
                    timer_q <= timer_q + TW'(1);
                    if (unlock_i) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (card_is_needed_i && !card_avail_i) begin
                        fail_q  <= 1'b1;
                        state_q <= StFail;
                    end else if (card_is_needed_i && !card_done_q) begin
                        enter_q      <= 1'b1;
                        card_is_in_q <= 1'b1;
                        state_q      <= StCard;
                    end else if (error_i || card_is_needed_i || timer_q == TW'(TIMEOUT - 1)) begin
                        // A repeated card request counts as an error.
                        if (retries_q < 3'(MAX_RETRY)) begin
                            retries_q   <= retries_q + 3'd1;
                            card_done_q <= 1'b0;
                            idx_q       <= '0;
                            gap_q       <= '0;
                            state_q     <= StGap;
                        end else begin
                            fail_q  <= 1'b1;
                            state_q <= StFail;
                        end
                    end
                end
                StCard: begin
                    card_done_q <= 1'b1;
                    timer_q     <= '0;
                    state_q     <= StWait;
                end
                StDone, StFail: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_o         = in_q;
    assign enter_o      = enter_q;
    assign card_is_in_o = card_is_in_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign retries_o    = retries_q;

endmodule

// File: doc/elc_code_sender.md
Name: elc_code_sender

Overview:
- Initiator side of the electronic-lock keypad/card interface. Drives `in`, `enter` and `card_is_in` into an `elc_top`-style lock controller.
- On `start`, sends a latched multi-digit code one digit per `enter` pulse, then waits for the lock's response (`unlock` / `error` / `card_is_needed`).
- Inserts the card when asked and retries on error or timeout. Used as an automated entry unit and as a bench stimulus source for the lock.

Parameters:
- DIGITS, 4, number of 3-bit digits in the code (1..8).
- GAP, 2, idle cycles between consecutive enter pulses (>=1).
- TIMEOUT, 16, cycles to wait for a lock response before treating it as an error (>=2).
- MAX_RETRY, 3, retries after the first attempt before declaring failure (0..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to send `code`; sampled only in IDLE.
- code  in  3*DIGITS  code to send, digit 0 in the MS 3 bits.
- card_avail  in  1  a card is present and may be inserted.
- unlock  in  1  lock response: access granted.
- error  in  1  lock response: wrong code / protocol error.
- card_is_needed  in  1  lock response: card required.
- in  out  3  digit presented to the lock.
- enter  out  1  one-cycle strobe qualifying `in` / `card_is_in`.
- card_is_in  out  1  card-insert flag, valid with `enter`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: lock unlocked.
- fail  out  1  one-cycle pulse: attempts exhausted or no card.
- retries  out  3  retries used in the current/last transaction.

Behaviour:
- All outputs registered. Reset (`reset`=0) immediately forces state IDLE and `in`=0, `enter`=0, `card_is_in`=0, `busy`=0, `done`=0, `fail`=0, `retries`=0, and clears all counters. Reset mid-transaction aborts with no `done`/`fail` pulse.
- IDLE: `start`=1 at edge N latches `code`, clears `retries` and goes to SEND. The first `enter`=1 is visible in cycle N+1. `start` outside IDLE is ignored.
- SEND: one cycle with `enter`=1, `in`=digit k, `card_is_in`=0. Digit k = code[3*(DIGITS-1-k)+:3], k=0..DIGITS-1.
  - If more digits remain, go to GAP; after the last digit, go to WAIT.
- GAP: GAP cycles with `enter`=0, `in`=0, then SEND with the next digit. Enter pulses are therefore GAP+1 cycles apart.
- WAIT: timer cleared on entry, increments each cycle. Responses are evaluated each cycle with priority unlock > card_is_needed > error > timeout.
  - `unlock`=1 -> DONE.
  - `card_is_needed`=1:
    - card not yet inserted this attempt and `card_avail`=1 -> CARD.
    - `card_avail`=0 -> FAIL.
    - card already inserted this attempt -> treated as error.
  - `error`=1, or timer reaches TIMEOUT-1 with no response:
    - `retries` < MAX_RETRY -> `retries`+1, clear the card-inserted flag, wait GAP cycles, then restart SEND at digit 0.
    - otherwise -> FAIL.
- CARD: one cycle with `enter`=1, `card_is_in`=1, `in`=0. Sets the card-inserted flag, then returns to WAIT with the timer cleared.
- DONE: `done`=1 for exactly one cycle, then IDLE. FAIL: `fail`=1 for exactly one cycle, then IDLE. `retries` holds its value in IDLE until the next `start`.
- Lock responses arriving in SEND/GAP/CARD are ignored; only WAIT samples them.
- `enter` is never high two consecutive cycles.
- `in` is 0 whenever `enter`=0.
- `card_is_in` is 0 whenever `enter`=0.

Test Plan:
- Reset low mid-SEND -> all outputs 0 in the same cycle; after release, IDLE with `busy`=0 and no `done`/`fail` pulse.
- DIGITS=4, GAP=2, code=3'b010,000,111,001, `start` pulse -> enter pulses 3 cycles apart with `in`=2,0,7,1. Respond `unlock`=1 two cycles after the last enter -> `done` pulse 1 cycle later, `retries`=0.
- Same code; respond `card_is_needed`, `card_avail`=1 -> one `enter`+`card_is_in` pulse with `in`=0. Then `unlock` -> `done`.
- `card_is_needed` with `card_avail`=0 -> `fail` pulse, no card pulse, `busy` drops the next cycle.
- Always respond `error`, MAX_RETRY=3 -> 4 full code sequences, then `fail` with `retries`=3.
- No response at all -> WAIT lasts TIMEOUT cycles per attempt, 4 attempts, then `fail`. Simultaneous `unlock`+`error` -> `done` (priority).
